fpu_in_xmtr: RTL and testbench

Synthesizable transmitter for the FPU_in interface, the input-side counterpart of the FPU_out result path. It buffers operation requests from the HVL proxy in a small FIFO, applies an optional per-request idle delay, and drives each operation onto the FPU input pins with a start/ready handshake. It then waits for the FPU's done pulse before issuing the next operation. It is compiled into the HDL side of the FPU_in agent and runs unchanged on emulation.

---
 rtl/fpu_in_xmtr_if.sv | 29 ++
 rtl/fpu_in_xmtr.sv | 142 ++++++++++++++
 tb/tb_fpu_in_xmtr.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_in_xmtr_if.sv
// Request and FPU pin bundle for the FPU_in transmitter.
// master: the transmitter (accepts requests, drives the FPU input pins).
// slave:  the environment (issues requests, models the FPU handshake).
interface fpu_in_xmtr_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic [1:0]  req_rnd;
  logic [3:0]  req_delay;
  logic        fpu_start;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rnd;
  logic        fpu_ready;
  logic        fpu_done;

  modport master (
    input  req_valid, req_a, req_b, req_op, req_rnd, req_delay, fpu_ready, fpu_done,
    output req_ready, fpu_start, fpu_a, fpu_b, fpu_op, fpu_rnd
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, req_rnd, req_delay, fpu_ready, fpu_done,
    input  req_ready, fpu_start, fpu_a, fpu_b, fpu_op, fpu_rnd
  );
endinterface

// File: rtl/fpu_in_xmtr.sv
// FPU_in transmitter: queues operation requests, waits the requested idle
// delay, drives one operation at a time with a start/ready handshake and
// waits for the done pulse (or a timeout) before issuing the next one.
module fpu_in_xmtr #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  fpu_in_xmtr_if.master bus,
  output logic          busy,
  output logic [15:0]   sent_count,
  output logic          timeout_err
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DELAY, DRIVE, WAIT_DONE} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [1:0]  rnd;
    logic [3:0]  dly;
  } entry_t;

  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, pop;
  entry_t      head;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        start_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic [1:0]  rnd_q;
  logic [15:0] sent_q;
  logic        err_q;
  logic        xfer, tmo;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = bus.req_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Request storage: pure data, so it is written without reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.req_a, bus.req_b, bus.req_op, bus.req_rnd, bus.req_delay};
    end
  end

  // Sequencer next state: pop in IDLE, count the idle delay, hold the
  // operation until accepted, then wait for done or give up at TIMEOUT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    pop     = 1'b0;
    xfer    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = head.dly;
          state_d = (head.dly == 4'd0) ? DRIVE : DELAY;
        end
      end
      DELAY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DRIVE;
      end
      DRIVE: begin
        if (bus.fpu_ready) begin
          xfer    = 1'b1;
          timer_d = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_q + 16'd1;
        // A done arriving on the last allowed cycle beats the timeout.
        if (bus.fpu_done) begin
          state_d = IDLE;
        end else if (timer_q == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, FIFO pointers, output registers and status counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rnd_q    <= '0;
      sent_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      start_q <= (state_d == DRIVE);
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        a_q      <= head.a;
        b_q      <= head.b;
        op_q     <= head.op;
        rnd_q    <= head.rnd;
      end
      if (xfer) sent_q <= sent_q + 16'd1;
      if (tmo)  err_q  <= 1'b1;
    end
  end

  assign bus.req_ready = !full;
  assign bus.fpu_start = start_q;
  assign bus.fpu_a     = a_q;
  assign bus.fpu_b     = b_q;
  assign bus.fpu_op    = op_q;
  assign bus.fpu_rnd   = rnd_q;
  assign busy          = (state_q != IDLE) || !empty;
  assign sent_count    = sent_q;
  assign timeout_err   = err_q;
endmodule

// File: tb/tb_fpu_in_xmtr.sv
// Bench for fpu_in_xmtr: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the transmitter.
module tb_fpu_in_xmtr;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clock;
  logic        reset;
  logic        busy;
  logic [15:0] sent_count;
  logic        timeout_err;

  fpu_in_xmtr_if bus();

  fpu_in_xmtr #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .sent_count (sent_count),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: every request not yet completed, head first, with its push edge.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [1:0]  rnd;
    logic [3:0]  dly;
    int          pe;
  } op_t;

  op_t         q[$];
  int          e;          // rising edges seen so far
  int          avail;      // earliest edge the head may be popped
  int          t_edge;     // edge at which the head was accepted
  bit          xfered;     // head accepted, waiting for done
  bit          m_err;
  logic [15:0] m_sent;
  int          done_lat;   // done arrives this many edges after acceptance; 0 = never
  bit          spur_en;    // random done pulses outside WAIT_DONE
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_bound(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: wait bound expired before the expected event", tag);
  endtask

  function automatic int pop_edge();
    return (q[0].pe + 1 > avail) ? q[0].pe + 1 : avail;
  endfunction

  function automatic bit head_popped();
    return (q.size() > 0) && (e >= pop_edge());
  endfunction

  // Start is visible from the pop edge plus the requested delay until accepted.
  function automatic bit exp_start();
    return (q.size() > 0) && !xfered && (e >= pop_edge() + int'(q[0].dly));
  endfunction

  function automatic bit exp_ready();
    return (q.size() - (head_popped() ? 1 : 0)) < DEPTH;
  endfunction

  task automatic complete();
    q.delete(0);
    xfered = 1'b0;
    avail  = e + 1;
  endtask

  task automatic check_outputs();
    chk("fpu_start", 64'(bus.fpu_start), 64'(exp_start()));
    if (exp_start()) begin
      chk("fpu_a",   64'(bus.fpu_a),   64'(q[0].a));
      chk("fpu_b",   64'(bus.fpu_b),   64'(q[0].b));
      chk("fpu_op",  64'(bus.fpu_op),  64'(q[0].op));
      chk("fpu_rnd", 64'(bus.fpu_rnd), 64'(q[0].rnd));
    end
    chk("sent_count",  64'(sent_count),  64'(m_sent));
    chk("busy",        64'(busy),        64'(q.size() > 0));
    chk("timeout_err", 64'(timeout_err), 64'(m_err));
  endtask

  // One clock: drive done, check req_ready, advance one edge, update model, check.
  task automatic step();
    bit  push;
    bit  xfer;
    bit  done;
    op_t ent;
    if (q.size() > 0 && xfered)
      bus.fpu_done = (done_lat != 0) && (e + 1 == t_edge + done_lat);
    else
      bus.fpu_done = spur_en && ($urandom_range(0, 3) == 0);
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready()));
    push    = bus.req_valid && exp_ready();
    xfer    = exp_start() && bus.fpu_ready;
    done    = bus.fpu_done;
    ent.a   = bus.req_a;
    ent.b   = bus.req_b;
    ent.op  = bus.req_op;
    ent.rnd = bus.req_rnd;
    ent.dly = bus.req_delay;
    @(posedge clock);
    e++;
    if (q.size() > 0 && xfered) begin
      if (done) complete();
      else if (e == t_edge + TMO) begin
        m_err = 1'b1;
        complete();
      end
    end
    if (xfer) begin
      xfered = 1'b1;
      t_edge = e;
      m_sent++;
    end
    if (push) begin
      ent.pe = e;
      q.push_back(ent);
    end
    #1;
    check_outputs();
  endtask

  task automatic set_req(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [1:0] rnd, input logic [3:0] d);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_rnd   = rnd;
    bus.req_delay = d;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [1:0] rnd, input logic [3:0] d);
    int n;
    n = 0;
    set_req(1'b1, a, b, op, rnd, d);
    while (!exp_ready() && n < 100) begin
      step();
      n++;
    end
    if (!exp_ready()) fail_bound("push_wait");
    else step();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_count(input int n, output int starts);
    starts = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.fpu_start) starts++;
    end
  endtask

  task automatic run_until_idle(input int limit, input string tag);
    int n;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      step();
      n++;
    end
    if (q.size() > 0) fail_bound(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int starts;
    int drv;
    int n;
    vectors = 0; miscompares = 0;
    e = 0; avail = 0; t_edge = 0; xfered = 1'b0; m_err = 1'b0; m_sent = '0;
    done_lat = 0; spur_en = 1'b0;
    set_req(1'b0, '0, '0, '0, '0, '0);
    bus.fpu_ready = 1'b0;
    bus.fpu_done  = 1'b0;
    reset = 1'b1;
    @(posedge clock); e++;
    @(posedge clock); e++;
    #1;

    // Reset values.
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_fpu_start", 64'(bus.fpu_start), 64'(0));
    chk("rst_fpu_a",     64'(bus.fpu_a),     64'(0));
    chk("rst_fpu_b",     64'(bus.fpu_b),     64'(0));
    chk("rst_fpu_op",    64'(bus.fpu_op),    64'(0));
    chk("rst_fpu_rnd",   64'(bus.fpu_rnd),   64'(0));
    chk("rst_busy",      64'(busy),          64'(0));
    chk("rst_sent",      64'(sent_count),    64'(0));
    chk("rst_err",       64'(timeout_err),   64'(0));
    reset = 1'b0;
    avail = e + 1;

    // Single operation, FPU always ready, done 4 edges after acceptance.
    bus.fpu_ready = 1'b1;
    done_lat = 4;
    push_req(32'h3F80_0000, 32'h4000_0000, 3'd0, 2'd0, 4'd0);
    run_count(10, starts);
    chk("single_starts", 64'(starts),     64'(1));
    chk("single_sent",   64'(sent_count), 64'(1));
    chk("single_busy",   64'(busy),       64'(0));

    // Delay of 3 and five refused DRIVE cycles before acceptance.
    bus.fpu_ready = 1'b0;
    push_req(32'hC0A0_0000, 32'h3F00_0000, 3'd5, 2'd2, 4'd3);
    drv = 0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      if (exp_start()) begin
        bus.fpu_ready = (drv >= 5);
        drv++;
      end else begin
        bus.fpu_ready = 1'b0;
      end
      step();
      if (bus.fpu_start) starts++;
    end
    chk("bp_drive_cycles", 64'(starts),     64'(6));
    chk("bp_sent",         64'(sent_count), 64'(2));

    // Fill the queue behind a stalled operation; the sixth request is held.
    bus.fpu_ready = 1'b0;
    done_lat = 2;
    for (int i = 0; i < 5; i++)
      push_req(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 3'(i), 2'(i), 4'd0);
    chk("full_ready", 64'(bus.req_ready), 64'(0));
    set_req(1'b1, 32'h1000_0005, 32'h2000_0005, 3'd5, 2'd1, 4'd0);
    for (int i = 0; i < 3; i++) step();
    chk("held_ready", 64'(bus.req_ready), 64'(0));
    bus.fpu_ready = 1'b1;
    push_req(32'h1000_0005, 32'h2000_0005, 3'd5, 2'd1, 4'd0);
    run_until_idle(200, "full_drain");
    chk("full_sent", 64'(sent_count), 64'(8));

    // Done on the very cycle the timeout would fire: done wins.
    done_lat = TMO;
    push_req(32'h4040_0000, 32'h4080_0000, 3'd2, 2'd3, 4'd0);
    run_until_idle(50, "dot_drain");
    chk("dot_err",  64'(timeout_err), 64'(0));
    chk("dot_sent", 64'(sent_count),  64'(9));

    // No done at all: both queued operations time out, flag is sticky.
    done_lat = 0;
    push_req(32'h0000_0001, 32'h0000_0002, 3'd1, 2'd0, 4'd1);
    push_req(32'h0000_0003, 32'h0000_0004, 3'd3, 2'd1, 4'd0);
    run_until_idle(100, "tmo_drain");
    chk("tmo_err",  64'(timeout_err), 64'(1));
    chk("tmo_sent", 64'(sent_count),  64'(11));

    // Reset while an operation is being driven with more queued behind it.
    bus.fpu_ready = 1'b0;
    done_lat = 3;
    push_req(32'hAAAA_0001, 32'hBBBB_0001, 3'd1, 2'd1, 4'd0);
    push_req(32'hAAAA_0002, 32'hBBBB_0002, 3'd2, 2'd2, 4'd0);
    push_req(32'hAAAA_0003, 32'hBBBB_0003, 3'd3, 2'd3, 4'd0);
    n = 0;
    while (!exp_start() && n < 20) begin
      step();
      n++;
    end
    if (!exp_start()) fail_bound("mid_drive_wait");
    #2;
    reset = 1'b1;
    #1;
    chk("mid_fpu_start", 64'(bus.fpu_start), 64'(0));
    chk("mid_fpu_a",     64'(bus.fpu_a),     64'(0));
    chk("mid_req_ready", 64'(bus.req_ready), 64'(1));
    chk("mid_busy",      64'(busy),          64'(0));
    chk("mid_sent",      64'(sent_count),    64'(0));
    chk("mid_err",       64'(timeout_err),   64'(0));
    @(posedge clock); e++;
    @(posedge clock); e++;
    #1;
    reset = 1'b0;
    q.delete();
    xfered = 1'b0;
    m_sent = '0;
    m_err  = 1'b0;
    avail  = e + 1;
    bus.fpu_ready = 1'b1;
    push_req(32'h3F80_0000, 32'hBF80_0000, 3'd4, 2'd2, 4'd2);
    run_until_idle(30, "post_rst_drain");
    chk("post_rst_sent", 64'(sent_count), 64'(1));

    // Random traffic, random backpressure, done latencies around TIMEOUT,
    // and stray done pulses outside WAIT_DONE.
    spur_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      set_req(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      bus.fpu_ready = ($urandom_range(0, 3) != 0);
      if (!xfered) done_lat = $urandom_range(1, 10);
      step();
    end
    bus.req_valid = 1'b0;
    spur_en = 1'b0;
    bus.fpu_ready = 1'b1;
    done_lat = 2;
    run_until_idle(400, "rand_drain");
    chk("final_busy", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
